// File: rtl/synth_scan_ctrl.sv
// Polyphonic key-scan controller: per-key note state, Avalon-MM register bank, and a per-sample
// scanner that sequences the oscillator/envelope datapath with a polyphony cap.
module synth_scan_ctrl #(
  parameter  int NUM_KEYS   = 128,
  parameter  int NUM_CTRL   = 16,
  parameter  int CTRL_W     = 20,
  parameter  int MAX_VOICES = 16,
  localparam int KEY_W      = $clog2(NUM_KEYS),
  localparam int CNT_W      = $clog2(MAX_VOICES + 1)
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       RUN,
  input  logic                       AVL_WRITE,
  input  logic                       AVL_READ,
  input  logic [7:0]                 AVL_ADDR,
  input  logic [31:0]                AVL_WRITEDATA,
  output logic [31:0]                AVL_READDATA,
  input  logic                       FIFO_FULL,
  output logic                       LD_FIFO,
  output logic [KEY_W-1:0]           KEY,
  output logic [6:0]                 VEL,
  output logic                       NOTE_ON,
  output logic                       ATT_ON,
  output logic                       VOICE_EN,
  output logic                       VOICE_REL,
  input  logic                       NOTE_END,
  input  logic                       ATT_OFF,
  output logic [CNT_W-1:0]           VOICE_CNT,
  output logic [NUM_CTRL*CTRL_W-1:0] CTRL_BUS
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CHECK, S_ON, S_OFF, S_WRITE} state_t;

  localparam logic [3:0]       CTRL_LIM = 4'(NUM_CTRL - 2);
  localparam logic [7:0]       KEY_LIM  = 8'(NUM_KEYS);
  localparam logic [KEY_W-1:0] KEY_LAST = KEY_W'(NUM_KEYS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_VOICES);

  state_t                             r_state, w_nxt;
  logic [KEY_W-1:0]                   r_key;
  logic [CNT_W-1:0]                   r_cnt, r_voice_cnt;
  logic                               r_ovf;
  logic [NUM_KEYS-1:0]                r_gate, r_active, r_att;
  logic [NUM_KEYS-1:0][6:0]           r_vel;
  logic [NUM_CTRL-1:0][CTRL_W-1:0]    r_ctrl;

  logic             w_last, w_key_ok, w_sus;
  logic [KEY_W-1:0] w_akey;
  logic             w_unused_ok;

  assign w_last      = (r_key == KEY_LAST);
  assign w_akey      = AVL_ADDR[KEY_W-1:0];
  assign w_key_ok    = ({1'b0, AVL_ADDR[6:0]} < KEY_LIM);
  assign w_sus       = (r_ctrl[6][6:0] >= 7'h40);
  assign w_unused_ok = ^AVL_WRITEDATA[31:CTRL_W];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:      if (RUN) w_nxt = S_WAIT;
      S_WAIT:      if (!FIFO_FULL) w_nxt = S_CHECK;
      S_CHECK:     w_nxt = (r_active[r_key] && (r_cnt < CNT_MAX)) ? S_ON : S_OFF;
      S_ON, S_OFF: w_nxt = w_last ? S_WRITE : S_CHECK;
      S_WRITE:     w_nxt = RUN ? S_WAIT : S_IDLE;
      default:     w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    VOICE_EN  = 1'b0;
    VOICE_REL = 1'b0;
    LD_FIFO   = 1'b0;
    case (r_state)
      S_ON:    VOICE_EN  = 1'b1;
      S_OFF:   VOICE_REL = 1'b1;
      S_WRITE: LD_FIFO   = 1'b1;
      default: ;
    endcase
  end

  // Scan updates first; the Avalon write below overrides them for the same key in the same cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_key       <= '0;
      r_cnt       <= '0;
      r_voice_cnt <= '0;
      r_ovf       <= 1'b0;
      r_gate      <= '0;
      r_active    <= '0;
      r_att       <= '0;
      r_vel       <= '0;
      r_ctrl      <= '0;
    end else begin
      case (r_state)
        S_ON: begin
          r_active[r_key] <= !NOTE_END;
          r_att[r_key]    <= r_att[r_key] & !ATT_OFF;
          r_cnt           <= r_cnt + 1'b1;
          r_key           <= w_last ? '0 : r_key + 1'b1;
        end
        S_OFF: begin
          // An active key landing here was skipped by the voice cap; it stays pending.
          if (r_active[r_key]) r_ovf <= 1'b1;
          r_key <= w_last ? '0 : r_key + 1'b1;
        end
        S_WRITE: begin
          r_voice_cnt <= r_cnt;
          r_cnt       <= '0;
          r_key       <= '0;
        end
        default: ;
      endcase
      if (AVL_WRITE) begin
        if (!AVL_ADDR[7]) begin
          if (w_key_ok) begin
            if (AVL_WRITEDATA[7]) begin
              r_gate[w_akey]   <= 1'b1;
              r_active[w_akey] <= 1'b1;
              r_att[w_akey]    <= 1'b1;
              r_vel[w_akey]    <= AVL_WRITEDATA[6:0];
            end else begin
              r_gate[w_akey]   <= 1'b0;
            end
          end
        end else if (AVL_ADDR[3:0] < CTRL_LIM) begin
          r_ctrl[AVL_ADDR[3:0]] <= AVL_WRITEDATA[CTRL_W-1:0];
        end else if (AVL_ADDR[3:0] == 4'd14) begin
          r_ovf <= 1'b0;
        end else if ((AVL_ADDR[3:0] == 4'd15) && AVL_WRITEDATA[0]) begin
          r_gate <= '0;
        end
      end
    end
  end

  always_comb begin
    AVL_READDATA = '0;
    if (AVL_READ) begin
      if (!AVL_ADDR[7]) begin
        if (w_key_ok) AVL_READDATA = 32'({r_gate[w_akey], r_vel[w_akey]});
      end else if (AVL_ADDR[3:0] < CTRL_LIM) begin
        AVL_READDATA = 32'(r_ctrl[AVL_ADDR[3:0]]);
      end else if (AVL_ADDR[3:0] == 4'd14) begin
        AVL_READDATA = 32'({r_ovf, r_voice_cnt});
      end
    end
  end

  assign KEY       = r_key;
  assign VEL       = r_vel[r_key];
  assign NOTE_ON   = r_gate[r_key] | w_sus;
  assign ATT_ON    = r_att[r_key];
  assign VOICE_CNT = r_voice_cnt;
  assign CTRL_BUS  = r_ctrl;

endmodule
